branch_resolve_unit: RTL and testbench

- Consumes the registered ALU flags (N, Z, C, V) from the execute-side subtract for the branch in the resolve stage.
- Evaluates the RV32 branch condition and compares the outcome against the front-end prediction.
- On mispredict, issues a registered redirect and a multi-cycle flush of the younger stages.
- Owns the 2-bit saturating branch history table (BHT) that the fetch stage reads for prediction, updating it with every resolved conditional branch.

---
 rtl/branch_resolve_unit.sv | 163 ++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Branch resolve stage: evaluates RV32 branch conditions from ALU flags, issues
// redirect + multi-cycle flush on mispredict, owns the 2-bit BHT. Optional BRU_STATS_EN adds counters.
module branch_resolve_unit #(
  parameter int         IDX_W        = 6,
  parameter int         FLUSH_CYCLES = 2,
  parameter logic [1:0] BHT_INIT     = 2'b01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        br_valid,
  input  logic        br_is_jump,
  input  logic [2:0]  br_funct3,
  input  logic        flag_n,
  input  logic        flag_z,
  input  logic        flag_c,
  input  logic        flag_v,
  input  logic        b_zero,
  input  logic [31:0] br_pc,
  input  logic [31:0] br_target,
  input  logic        pred_taken,
  input  logic [31:0] pred_target,
  input  logic [31:0] lookup_pc,
  output logic        lookup_taken,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush_d,
  output logic        flush_e
`ifdef BRU_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);

  localparam int         ENTRIES  = 1 << IDX_W;
  localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

  typedef enum logic {S_IDLE, S_FLUSH} state_t;

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_cnt, w_cnt_nxt;
  logic        r_redirect, w_redirect_nxt;
  logic [31:0] r_redirect_pc, w_redirect_pc_nxt;
  logic        r_flush, w_flush_nxt;

  logic [1:0]  r_bht [ENTRIES];

  logic        w_geu, w_lt, w_cond, w_legal, w_taken, w_mispredict;
  logic        w_accept, w_bht_we;
  logic [31:0] w_correct_pc;
  logic [IDX_W-1:0] w_widx, w_ridx;
  logic [1:0]  w_ctr, w_ctr_nxt;
  logic        w_unused_lookup;

  // Unsigned geu uses b_zero because the ALU carry reads 0 when rs2 is zero.
  always_comb begin
    w_geu   = flag_c | b_zero;
    w_lt    = flag_n ^ flag_v;
    w_cond  = 1'b0;
    w_legal = 1'b1;
    case (br_funct3)
      3'b000:  w_cond = flag_z;
      3'b001:  w_cond = ~flag_z;
      3'b100:  w_cond = w_lt;
      3'b101:  w_cond = ~w_lt;
      3'b110:  w_cond = ~w_geu;
      3'b111:  w_cond = w_geu;
      default: w_legal = 1'b0;
    endcase
  end

  assign w_taken      = br_is_jump | w_cond;
  assign w_correct_pc = w_taken ? br_target : br_pc + 32'd4;
  assign w_mispredict = br_valid & ((w_taken != pred_taken) |
                                    (w_taken & (pred_target != br_target)));
  assign w_accept     = br_valid & (r_state == S_IDLE);
  assign w_bht_we     = w_accept & ~br_is_jump & w_legal;

  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_redirect_nxt    = 1'b0;
    w_redirect_pc_nxt = r_redirect_pc;
    w_flush_nxt       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept & w_mispredict) begin
          w_redirect_nxt    = 1'b1;
          w_redirect_pc_nxt = w_correct_pc;
          w_flush_nxt       = 1'b1;
          w_cnt_nxt         = CNT_INIT;
          w_state_nxt       = (FLUSH_CYCLES > 1) ? S_FLUSH : S_IDLE;
        end
      end
      S_FLUSH: begin
        if (r_cnt == 3'd0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_flush_nxt = 1'b1;
          w_cnt_nxt   = r_cnt - 3'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= 3'd0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= 32'd0;
      r_flush       <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_redirect    <= w_redirect_nxt;
      r_redirect_pc <= w_redirect_pc_nxt;
      r_flush       <= w_flush_nxt;
    end
  end

  assign redirect_valid = r_redirect;
  assign redirect_pc    = r_redirect_pc;
  assign flush_d        = r_flush;
  assign flush_e        = r_flush;

  assign w_widx    = br_pc[IDX_W+1:2];
  assign w_ridx    = lookup_pc[IDX_W+1:2];
  assign w_ctr     = r_bht[w_widx];
  assign w_ctr_nxt = w_cond ? ((w_ctr == 2'd3) ? 2'd3 : w_ctr + 2'd1)
                            : ((w_ctr == 2'd0) ? 2'd0 : w_ctr - 2'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) r_bht[i] <= BHT_INIT;
    end else if (w_bht_we) begin
      r_bht[w_widx] <= w_ctr_nxt;
    end
  end

  // Array read is pre-edge, so a same-cycle update is not visible until next cycle.
  assign lookup_taken    = r_bht[w_ridx][1];
  assign w_unused_lookup = ^{lookup_pc[31:IDX_W+2], lookup_pc[1:0]};

`ifdef BRU_STATS_EN
  logic [31:0] r_stat_br, r_stat_mp;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_br <= 32'd0;
      r_stat_mp <= 32'd0;
    end else begin
      if (w_accept)                r_stat_br <= r_stat_br + 32'd1;
      if (w_accept & w_mispredict) r_stat_mp <= r_stat_mp + 32'd1;
    end
  end

  assign stat_branches    = r_stat_br;
  assign stat_mispredicts = r_stat_mp;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: redirect/flush timing, condition decode, BHT saturation, reset mid-flush.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        br_valid, br_is_jump;
  logic [2:0]  br_funct3;
  logic        flag_n, flag_z, flag_c, flag_v, b_zero;
  logic [31:0] br_pc, br_target, pred_target, lookup_pc;
  logic        pred_taken;
  logic        lookup_taken, redirect_valid, flush_d, flush_e;
  logic [31:0] redirect_pc;
`ifdef BRU_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  int vecs = 0;
  int errs = 0;

  branch_resolve_unit dut (
    .clk(clk), .reset(reset),
    .br_valid(br_valid), .br_is_jump(br_is_jump), .br_funct3(br_funct3),
    .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v), .b_zero(b_zero),
    .br_pc(br_pc), .br_target(br_target), .pred_taken(pred_taken), .pred_target(pred_target),
    .lookup_pc(lookup_pc), .lookup_taken(lookup_taken),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush_d(flush_d), .flush_e(flush_e)
`ifdef BRU_STATS_EN
    , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // nzcvb = {flag_n, flag_z, flag_c, flag_v, b_zero}
  task automatic drive(input logic j, input logic [2:0] f3, input logic [4:0] nzcvb,
                       input logic [31:0] pc, input logic [31:0] tgt,
                       input logic pt, input logic [31:0] ptgt);
    br_valid = 1'b1; br_is_jump = j; br_funct3 = f3;
    {flag_n, flag_z, flag_c, flag_v, b_zero} = nzcvb;
    br_pc = pc; br_target = tgt; pred_taken = pt; pred_target = ptgt;
  endtask

  task automatic idle();
    br_valid = 1'b0; br_is_jump = 1'b0; br_funct3 = 3'b000;
    {flag_n, flag_z, flag_c, flag_v, b_zero} = 5'b0;
    br_pc = 32'd0; br_target = 32'd0; pred_taken = 1'b0; pred_target = 32'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1; idle(); lookup_pc = 32'h40;
    step(); step();
    reset = 1'b0; #1;
    vecs++; if (lookup_taken !== 1'b0) begin errs++; $display("FAIL rst_lookup got %b want 0", lookup_taken); end
    vecs++; if (redirect_valid !== 1'b0) begin errs++; $display("FAIL rst_redirect got %b want 0", redirect_valid); end
    vecs++; if ({flush_d, flush_e} !== 2'b00) begin errs++; $display("FAIL rst_flush got %b%b want 00", flush_d, flush_e); end
    vecs++; if (redirect_pc !== 32'h0) begin errs++; $display("FAIL rst_rpc got %h want 0", redirect_pc); end
  endtask

  task automatic test_beq_mispredict();
    lookup_pc = 32'h100;
    drive(1'b0, 3'b000, 5'b01000, 32'h100, 32'h180, 1'b0, 32'h0);
    #1;
    vecs++; if (lookup_taken !== 1'b0) begin errs++; $display("FAIL beq_bht_pre got %b want 0", lookup_taken); end
    step();
    idle();
    vecs++; if (redirect_valid !== 1'b1) begin errs++; $display("FAIL beq_redirect got %b want 1", redirect_valid); end
    vecs++; if (redirect_pc !== 32'h180) begin errs++; $display("FAIL beq_rpc got %h want 180", redirect_pc); end
    vecs++; if ({flush_d, flush_e} !== 2'b11) begin errs++; $display("FAIL beq_flush1 got %b%b want 11", flush_d, flush_e); end
    vecs++; if (lookup_taken !== 1'b1) begin errs++; $display("FAIL beq_bht_post got %b want 1", lookup_taken); end
    step();
    vecs++; if (redirect_valid !== 1'b0) begin errs++; $display("FAIL beq_pulse got %b want 0", redirect_valid); end
    vecs++; if ({flush_d, flush_e} !== 2'b11) begin errs++; $display("FAIL beq_flush2 got %b%b want 11", flush_d, flush_e); end
    vecs++; if (redirect_pc !== 32'h180) begin errs++; $display("FAIL beq_rpc_hold got %h want 180", redirect_pc); end
    step();
    vecs++; if ({flush_d, flush_e} !== 2'b00) begin errs++; $display("FAIL beq_flush3 got %b%b want 00", flush_d, flush_e); end
  endtask

  task automatic test_bgeu_correct();
    lookup_pc = 32'h1F0;
    drive(1'b0, 3'b111, 5'b00001, 32'h1F0, 32'h200, 1'b1, 32'h200);
    #1;
    vecs++; if (lookup_taken !== 1'b0) begin errs++; $display("FAIL bgeu_bht_pre got %b want 0", lookup_taken); end
    step();
    idle();
    vecs++; if (redirect_valid !== 1'b0) begin errs++; $display("FAIL bgeu_redirect got %b want 0", redirect_valid); end
    vecs++; if ({flush_d, flush_e} !== 2'b00) begin errs++; $display("FAIL bgeu_flush got %b%b want 00", flush_d, flush_e); end
    vecs++; if (lookup_taken !== 1'b1) begin errs++; $display("FAIL bgeu_bht_post got %b want 1", lookup_taken); end
  endtask

  task automatic test_flush_window();
    // index 0 counter is 2 after the beq test
    lookup_pc = 32'h300;
    drive(1'b0, 3'b001, 5'b01000, 32'h300, 32'h380, 1'b1, 32'h380);
    #1;
    vecs++; if (lookup_taken !== 1'b1) begin errs++; $display("FAIL bne_bht_pre got %b want 1", lookup_taken); end
    step();
    vecs++; if (redirect_valid !== 1'b1) begin errs++; $display("FAIL bne_redirect got %b want 1", redirect_valid); end
    vecs++; if (redirect_pc !== 32'h304) begin errs++; $display("FAIL bne_rpc got %h want 304", redirect_pc); end
    vecs++; if (lookup_taken !== 1'b0) begin errs++; $display("FAIL bne_bht_post got %b want 0", lookup_taken); end
    drive(1'b0, 3'b000, 5'b01000, 32'h300, 32'h500, 1'b0, 32'h0);
    step();
    vecs++; if (redirect_valid !== 1'b0) begin errs++; $display("FAIL win_redirect1 got %b want 0", redirect_valid); end
    vecs++; if (flush_d !== 1'b1) begin errs++; $display("FAIL win_flush got %b want 1", flush_d); end
    vecs++; if (lookup_taken !== 1'b0) begin errs++; $display("FAIL win_bht1 got %b want 0", lookup_taken); end
    step();
    idle();
    vecs++; if (redirect_valid !== 1'b0) begin errs++; $display("FAIL win_redirect2 got %b want 0", redirect_valid); end
    vecs++; if (flush_d !== 1'b0) begin errs++; $display("FAIL win_flush_end got %b want 0", flush_d); end
    vecs++; if (redirect_pc !== 32'h304) begin errs++; $display("FAIL win_rpc got %h want 304", redirect_pc); end
    vecs++; if (lookup_taken !== 1'b0) begin errs++; $display("FAIL win_bht2 got %b want 0", lookup_taken); end
  endtask

  task automatic test_saturate();
    logic exp_up [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic exp_dn [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    lookup_pc = 32'h80;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 3'b000, 5'b01000, 32'h80, 32'h90, 1'b1, 32'h90);
      #1;
      vecs++; if (lookup_taken !== exp_up[i]) begin errs++; $display("FAIL sat_up[%0d] got %b want %b", i, lookup_taken, exp_up[i]); end
      step();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 3'b000, 5'b00000, 32'h80, 32'h90, 1'b0, 32'h0);
      #1;
      vecs++; if (lookup_taken !== exp_dn[i]) begin errs++; $display("FAIL sat_dn[%0d] got %b want %b", i, lookup_taken, exp_dn[i]); end
      step();
    end
    idle(); #1;
    vecs++; if (lookup_taken !== 1'b0) begin errs++; $display("FAIL sat_floor got %b want 0", lookup_taken); end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 3'b000, 5'b01000, 32'h80, 32'h90, 1'b1, 32'h90);
      step();
    end
    idle(); #1;
    vecs++; if (lookup_taken !== 1'b1) begin errs++; $display("FAIL sat_recover got %b want 1", lookup_taken); end
  endtask

  task automatic test_bht_no_update();
    lookup_pc = 32'hC8;
    drive(1'b1, 3'b000, 5'b00000, 32'hC8, 32'h40, 1'b0, 32'h0);
    step();
    idle();
    vecs++; if (redirect_pc !== 32'h40) begin errs++; $display("FAIL jal_rpc got %h want 40", redirect_pc); end
    vecs++; if (lookup_taken !== 1'b0) begin errs++; $display("FAIL jal_bht got %b want 0", lookup_taken); end
    step(); step();
    lookup_pc = 32'hD0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 3'b011, 5'b01000, 32'hD0, 32'h60, 1'b0, 32'h0);
      step();
      vecs++; if (redirect_valid !== 1'b0) begin errs++; $display("FAIL illegal_redirect[%0d] got %b want 0", i, redirect_valid); end
    end
    drive(1'b0, 3'b000, 5'b01000, 32'hD0, 32'h60, 1'b1, 32'h60);
    step();
    idle();
    vecs++; if (lookup_taken !== 1'b1) begin errs++; $display("FAIL illegal_bht got %b want 1", lookup_taken); end
  endtask

  task automatic test_conditions();
    logic [2:0]  f3   [13] = '{3'b100, 3'b101, 3'b101, 3'b110, 3'b110, 3'b111, 3'b010,
                               3'b011, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000};
    logic        jmp  [13] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0};
    logic [4:0]  fl   [13] = '{5'b10000, 5'b10010, 5'b10000, 5'b00100, 5'b00000, 5'b00000, 5'b01000,
                               5'b01000, 5'b00000, 5'b00000, 5'b01000, 5'b01000, 5'b00000};
    logic [31:0] pc   [13] = '{32'h1000, 32'h1010, 32'h1020, 32'h1030, 32'h1040, 32'h1050, 32'h1060,
                               32'h1070, 32'h1080, 32'h1090, 32'h10A0, 32'hFFFFFFFC, 32'h10B0};
    logic [31:0] tgt  [13] = '{32'h1100, 32'h1200, 32'h1300, 32'h1400, 32'h1500, 32'h1600, 32'h1700,
                               32'h1700, 32'h1800, 32'h1804, 32'h2000, 32'h10, 32'h3000};
    logic        pt   [13] = '{0, 0, 1, 0, 0, 1, 1, 0, 0, 1, 1, 1, 1};
    logic [31:0] ptg  [13] = '{32'h0, 32'h0, 32'h1300, 32'h0, 32'h0, 32'h1600, 32'h1700,
                               32'h0, 32'h0, 32'h1900, 32'h2000, 32'h10, 32'h3000};
    logic        e_rv [13] = '{1, 1, 1, 0, 1, 1, 1, 0, 1, 1, 0, 1, 1};
    logic [31:0] e_pc [13] = '{32'h1100, 32'h1200, 32'h1024, 32'h0, 32'h1500, 32'h1054, 32'h1064,
                               32'h0, 32'h1800, 32'h1804, 32'h0, 32'h0, 32'h10B4};
    logic [31:0] last_pc;
    last_pc = redirect_pc;
    for (int i = 0; i < 13; i++) begin
      drive(jmp[i], f3[i], fl[i], pc[i], tgt[i], pt[i], ptg[i]);
      step();
      idle();
      if (e_rv[i]) last_pc = e_pc[i];
      vecs++; if (redirect_valid !== e_rv[i]) begin errs++; $display("FAIL cond[%0d]_redirect got %b want %b", i, redirect_valid, e_rv[i]); end
      vecs++; if (redirect_pc !== last_pc) begin errs++; $display("FAIL cond[%0d]_rpc got %h want %h", i, redirect_pc, last_pc); end
      vecs++; if (flush_e !== e_rv[i]) begin errs++; $display("FAIL cond[%0d]_flush got %b want %b", i, flush_e, e_rv[i]); end
      step(); step();
    end
  endtask

  task automatic test_reset_mid_flush();
    lookup_pc = 32'h80;
    drive(1'b0, 3'b000, 5'b01000, 32'h400, 32'h480, 1'b0, 32'h0);
    step();
    idle();
    vecs++; if (redirect_valid !== 1'b1) begin errs++; $display("FAIL rmf_redirect got %b want 1", redirect_valid); end
    reset = 1'b1;
    step();
    vecs++; if ({flush_d, flush_e} !== 2'b00) begin errs++; $display("FAIL rmf_flush got %b%b want 00", flush_d, flush_e); end
    vecs++; if (redirect_valid !== 1'b0) begin errs++; $display("FAIL rmf_rv got %b want 0", redirect_valid); end
    vecs++; if (redirect_pc !== 32'h0) begin errs++; $display("FAIL rmf_rpc got %h want 0", redirect_pc); end
    vecs++; if (lookup_taken !== 1'b0) begin errs++; $display("FAIL rmf_bht got %b want 0", lookup_taken); end
    reset = 1'b0;
    drive(1'b0, 3'b000, 5'b01000, 32'h500, 32'h5A0, 1'b0, 32'h0);
    step();
    idle();
    vecs++; if (redirect_valid !== 1'b1) begin errs++; $display("FAIL rmf_again_rv got %b want 1", redirect_valid); end
    vecs++; if (redirect_pc !== 32'h5A0) begin errs++; $display("FAIL rmf_again_rpc got %h want 5a0", redirect_pc); end
    vecs++; if ({flush_d, flush_e} !== 2'b11) begin errs++; $display("FAIL rmf_again_f1 got %b%b want 11", flush_d, flush_e); end
    step();
    vecs++; if ({flush_d, flush_e} !== 2'b11) begin errs++; $display("FAIL rmf_again_f2 got %b%b want 11", flush_d, flush_e); end
    step();
    vecs++; if ({flush_d, flush_e} !== 2'b00) begin errs++; $display("FAIL rmf_again_f3 got %b%b want 00", flush_d, flush_e); end
  endtask

  initial begin
    test_reset();
    test_beq_mispredict();
    test_bgeu_correct();
    test_flush_window();
    test_saturate();
    test_bht_no_update();
    test_conditions();
    test_reset_mid_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
